// File: rtl/z80_bitop_rmw_unit.sv
// z80_bitop_rmw_unit
// Read-modify-write engine for the Z80 BIT / SET / RES instructions on a
// memory operand addressed by (HL) or (IX+d)/(IY+d). One request is taken in
// IDLE; the effective address is latched, the operand is read, modified and,
// for SET/RES, written back. Flags and the final value are reported with a
// one-cycle done pulse.
//
// Optional feature macro: Z80_UNDOC_INDEXED_COPY_EN
//   Defined   : indexed SET/RES also copy the result into register reg_sel
//               (undocumented DDCB/FDCB behaviour) via reg_we / reg_wsel.
//   Undefined : reg_we and reg_wsel are tied to zero.
module z80_bitop_rmw_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  localparam int BIT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [BIT_W-1:0]  bit_sel,
  input  logic              indexed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        disp,
  input  logic [2:0]        reg_sel,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic [DATA_W-1:0] result,
  output logic              reg_we,
  output logic [2:0]        reg_wsel
);

  // Operation encodings as delivered by the decoder.
  localparam logic [1:0] OP_BIT = 2'b00;
  localparam logic [1:0] OP_RES = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t              state_reg;
  state_t              state_next;

  logic [1:0]          op_reg;
  logic [BIT_W-1:0]    bit_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic                flag_z_reg;
  logic [DATA_W-1:0]   result_reg;

  logic [ADDR_W-1:0]   disp_ext;
  logic [ADDR_W-1:0]   eff_addr;
  logic [DATA_W-1:0]   bit_mask;
  logic                accept;

  // Effective address: displacement is sign-extended and the sum wraps
  // naturally at the address width.
  assign disp_ext = {{(ADDR_W-8){disp[7]}}, disp};
  assign eff_addr = indexed ? (base_addr + disp_ext) : base_addr;

  // One-hot mask for the latched bit index.
  assign bit_mask = {{(DATA_W-1){1'b0}}, 1'b1} << bit_reg;

  // A request is only taken while idle; start is ignored at all other times.
  assign accept = (state_reg == IDLE) && start;

  // State register; reset lands in IDLE immediately, which drops mem_req
  // and busy combinationally without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and bus/handshake outputs, all decoded from the current state.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (op == OP_ILL) ? DONE : RD;
        end
      end
      RD: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          state_next = (op_reg == OP_BIT) ? DONE : WR;
        end
      end
      WR: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        err        = (op_reg == OP_ILL);
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture: operation, bit index and address are frozen at accept
  // so the bus address stays stable through any number of wait states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg   <= OP_BIT;
      bit_reg  <= '0;
      addr_reg <= '0;
    end else if (accept) begin
      op_reg   <= op;
      bit_reg  <= bit_sel;
      addr_reg <= eff_addr;
    end
  end

  // Read capture and modify: BIT updates the flag and result directly,
  // SET/RES precompute the write data so it is stable for the whole WR phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdata_reg  <= '0;
      flag_z_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      if ((state_reg == RD) && mem_ack) begin
        if (op_reg == OP_BIT) begin
          flag_z_reg <= ~mem_rdata[bit_reg];
          result_reg <= mem_rdata;
        end else if (op_reg == OP_SET) begin
          wdata_reg <= mem_rdata | bit_mask;
        end else begin
          wdata_reg <= mem_rdata & ~bit_mask;
        end
      end
      if ((state_reg == WR) && mem_ack) begin
        result_reg <= wdata_reg;
      end
    end
  end

  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign flag_z    = flag_z_reg;
  assign result    = result_reg;

`ifdef Z80_UNDOC_INDEXED_COPY_EN
  logic [2:0] rsel_reg;
  logic       copy_reg;

  // Copy-to-register qualification is decided at accept: only indexed
  // SET/RES whose target is a real register (not the (HL) slot 110).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel_reg <= 3'b000;
      copy_reg <= 1'b0;
    end else if (accept) begin
      rsel_reg <= reg_sel;
      copy_reg <= indexed && ((op == OP_RES) || (op == OP_SET)) &&
                  (reg_sel != 3'b110);
    end
  end

  assign reg_we   = (state_reg == DONE) && copy_reg;
  assign reg_wsel = rsel_reg;
`else
  logic unused_reg_sel;

  // Register copy disabled: the selector input has no consumer.
  assign unused_reg_sel = ^reg_sel;
  assign reg_we         = 1'b0;
  assign reg_wsel       = 3'b000;
`endif

endmodule

// File: tb/tb_z80_bitop_rmw_unit.sv
// Self-checking bench for z80_bitop_rmw_unit: directed cases pinned to
// hand-computed values, then randomized requests with random wait states,
// checked every cycle against a transaction-level model.
module tb_z80_bitop_rmw_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [2:0]  bit_sel;
  logic        indexed;
  logic [15:0] base_addr;
  logic [7:0]  disp;
  logic [2:0]  reg_sel;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        done;
  logic        err;
  logic        flag_z;
  logic [7:0]  result;
  logic        reg_we;
  logic [2:0]  reg_wsel;

  always #5 clk = ~clk;

  z80_bitop_rmw_unit #(.DATA_W(8), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .bit_sel(bit_sel),
    .indexed(indexed), .base_addr(base_addr), .disp(disp), .reg_sel(reg_sel),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .done(done), .err(err), .flag_z(flag_z), .result(result),
    .reg_we(reg_we), .reg_wsel(reg_wsel)
  );

  // Memory contents and architectural model state.
  logic [7:0]  mem [0:65535];
  logic        m_flag_z;
  logic [7:0]  m_result;
  logic [2:0]  m_wsel;

  // Expected outputs for the cycle currently in flight.
  logic        chk_en;
  logic        e_busy, e_req, e_we, e_done, e_err, e_reg_we;
  logic [15:0] e_addr;
  logic [7:0]  e_wdata;

  // Observations used by the literal checks.
  int          cyc;
  int          done_cycle;
  logic [15:0] seen_addr;
  logic [7:0]  seen_wdata;
  logic        seen_err;
  logic        seen_reg_we;
  logic        seen_req_since_start;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input logic b, input logic rq, input logic we, input logic dn,
                         input logic er, input logic rw, input logic [15:0] a, input logic [7:0] wd);
    e_busy = b; e_req = rq; e_we = we; e_done = dn; e_err = er; e_reg_we = rw;
    e_addr = a; e_wdata = wd;
  endtask

  // Randomize request inputs while the unit is busy; they must be ignored.
  task automatic scramble();
    start     = 1'($urandom_range(0, 1));
    op        = 2'($urandom);
    bit_sel   = 3'($urandom);
    indexed   = 1'($urandom);
    base_addr = 16'($urandom);
    disp      = 8'($urandom);
    reg_sel   = 3'($urandom);
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",    32'(busy),    32'(e_busy));
      check("mem_req", 32'(mem_req), 32'(e_req));
      check("done",    32'(done),    32'(e_done));
      check("err",     32'(err),     32'(e_err));
      check("flag_z",  32'(flag_z),  32'(m_flag_z));
      check("result",  32'(result),  32'(m_result));
      check("reg_we",  32'(reg_we),  32'(e_reg_we));
      if (e_req) begin
        check("mem_we",   32'(mem_we),   32'(e_we));
        check("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) check("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
      end
`ifdef Z80_UNDOC_INDEXED_COPY_EN
      if (e_done) check("reg_wsel", 32'(reg_wsel), 32'(m_wsel));
`else
      check("reg_wsel", 32'(reg_wsel), 32'(0));
`endif
    end
    if (mem_req) begin
      seen_addr = mem_addr;
      seen_req_since_start = 1'b1;
    end
    if (mem_req && mem_we) seen_wdata = mem_wdata;
    if (done) begin
      done_cycle  = cyc;
      seen_err    = err;
      seen_reg_we = reg_we;
    end
  end

  // One complete request: start cycle, read phase, optional write phase,
  // done cycle and a trailing idle cycle. Expectations follow directly from
  // the latency rules: (rdw+1) read cycles, (wrw+1) write cycles, one done.
  task automatic run_txn(input logic [1:0] o, input int b, input logic idx,
                         input logic [15:0] base, input logic [7:0] d,
                         input logic [2:0] rs, input int rdw, input int wrw);
    logic [15:0] ea;
    logic [7:0]  rd;
    logic [7:0]  wv;
    logic [7:0]  mask;
    logic        copy;
    ea   = idx ? 16'(base + {{8{d[7]}}, d}) : base;
    mask = 8'(8'h01 << b);
    rd   = mem[ea];
    wv   = rd;
    @(posedge clk); #1;
    start = 1'b1; op = o; bit_sel = 3'(b); indexed = idx; base_addr = base;
    disp = d; reg_sel = rs;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
    cyc = 0; done_cycle = -1; seen_req_since_start = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, ea, 8'h00);
    if (o != 2'b11) begin
      for (int w = 0; w <= rdw; w++) begin
        @(posedge clk); #1; scramble(); cyc++;
        mem_ack   = (w == rdw);
        mem_rdata = (w == rdw) ? rd : 8'($urandom);
        set_exp(1, 1, 0, 0, 0, 0, ea, 8'h00);
      end
      if (o != 2'b00) begin
        wv = (o == 2'b10) ? (rd | mask) : (rd & ~mask);
        for (int w = 0; w <= wrw; w++) begin
          @(posedge clk); #1; scramble(); cyc++;
          mem_ack   = (w == wrw);
          mem_rdata = 8'($urandom);
          set_exp(1, 1, 1, 0, 0, 0, ea, wv);
        end
        mem[ea] = wv;
      end
    end
    @(posedge clk); #1; scramble(); cyc++;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
    if (o == 2'b00) begin
      m_flag_z = ~rd[b];
      m_result = rd;
    end else if (o != 2'b11) begin
      m_result = wv;
    end
    m_wsel = rs;
`ifdef Z80_UNDOC_INDEXED_COPY_EN
    copy = idx && (o == 2'b01 || o == 2'b10) && (rs != 3'b110);
`else
    copy = 1'b0;
`endif
    set_exp(1, 0, 0, 1, (o == 2'b11), copy, ea, 8'h00);
    @(posedge clk); #1; scramble(); start = 1'b0; cyc++;
    mem_ack = 1'($urandom_range(0, 1));
    set_exp(0, 0, 0, 0, 0, 0, ea, 8'h00);
    $display("[TB] txn op=%0d b=%0d idx=%0d addr=%04h rd=%02h result=%02h waits=%0d/%0d",
             o, b, idx, ea, rd, m_result, rdw, wrw);
  endtask

  // Reset asserted in the middle of a stalled write phase.
  task automatic reset_mid_write();
    logic [15:0] ea;
    logic [7:0]  wv;
    ea = 16'h3456;
    wv = mem[ea] | 8'h20;
    @(posedge clk); #1;
    start = 1'b1; op = 2'b10; bit_sel = 3'd5; indexed = 1'b0; base_addr = ea;
    disp = 8'h00; reg_sel = 3'd1; mem_ack = 1'b0;
    cyc = 0; set_exp(0, 0, 0, 0, 0, 0, ea, 8'h00);
    @(posedge clk); #1; start = 1'b0; cyc++;
    mem_ack = 1'b1; mem_rdata = mem[ea];
    set_exp(1, 1, 0, 0, 0, 0, ea, 8'h00);
    @(posedge clk); #1; cyc++;
    mem_ack = 1'b0; mem_rdata = 8'($urandom);
    set_exp(1, 1, 1, 0, 0, 0, ea, wv);
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid mem_req", 32'(mem_req), 32'(0));
    check("rst_mid busy",    32'(busy),    32'(0));
    check("rst_mid done",    32'(done),    32'(0));
    check("rst_mid mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mid result",  32'(result),  32'(0));
    m_flag_z = 1'b0; m_result = 8'h00; m_wsel = 3'd0;
    set_exp(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
    mem_ack = 1'b1;
    @(posedge clk); #3;
    reset = 1'b0;
    mem_ack = 1'b0;
    $display("[TB] txn reset during write at addr=%04h", ea);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_en = 1'b0;
    reset = 1'b1;
    start = 1'b0; op = 2'b00; bit_sel = 3'd0; indexed = 1'b0;
    base_addr = 16'h0000; disp = 8'h00; reg_sel = 3'd0;
    mem_rdata = 8'h00; mem_ack = 1'b0;
    m_flag_z = 1'b0; m_result = 8'h00; m_wsel = 3'd0;
    cyc = 0; done_cycle = -1; seen_addr = '0; seen_wdata = '0;
    seen_err = 1'b0; seen_reg_we = 1'b0; seen_req_since_start = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 16'h0000, 8'h00);
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    #22;
    // Reset values.
    check("rst busy",      32'(busy),      32'(0));
    check("rst mem_req",   32'(mem_req),   32'(0));
    check("rst mem_we",    32'(mem_we),    32'(0));
    check("rst done",      32'(done),      32'(0));
    check("rst err",       32'(err),       32'(0));
    check("rst flag_z",    32'(flag_z),    32'(0));
    check("rst reg_we",    32'(reg_we),    32'(0));
    check("rst mem_addr",  32'(mem_addr),  32'(0));
    check("rst mem_wdata", 32'(mem_wdata), 32'(0));
    check("rst result",    32'(result),    32'(0));
    check("rst reg_wsel",  32'(reg_wsel),  32'(0));
    @(posedge clk); #3;
    reset = 1'b0;
    chk_en = 1'b1;

    // SET b=3 at 0x1000, read 0x00 -> write 0x08, done at cycle 3.
    mem[16'h1000] = 8'h00;
    run_txn(2'b10, 3, 1'b0, 16'h1000, 8'h00, 3'd0, 0, 0);
    check("lit set result", 32'(result), 32'h08);
    check("lit set addr", 32'(seen_addr), 32'h1000);
    check("lit set wdata", 32'(seen_wdata), 32'h08);
    check("lit set done_cycle", 32'(done_cycle), 32'd3);

    // RES b=7 at 0x2000 + (-2), read 0xFF -> write 0x7F at 0x1FFE.
    mem[16'h1FFE] = 8'hFF;
    run_txn(2'b01, 7, 1'b1, 16'h2000, 8'hFE, 3'd0, 0, 0);
    check("lit res addr", 32'(seen_addr), 32'h1FFE);
    check("lit res wdata", 32'(seen_wdata), 32'h7F);
    check("lit res result", 32'(result), 32'h7F);

    // BIT b=0 on 0xFE and then on 0x01.
    mem[16'h4000] = 8'hFE;
    run_txn(2'b00, 0, 1'b0, 16'h4000, 8'h00, 3'd0, 0, 0);
    check("lit bit0 flag_z", 32'(flag_z), 32'd1);
    check("lit bit0 done_cycle", 32'(done_cycle), 32'd2);
    mem[16'h4000] = 8'h01;
    run_txn(2'b00, 0, 1'b0, 16'h4000, 8'h00, 3'd0, 0, 0);
    check("lit bit1 flag_z", 32'(flag_z), 32'd0);
    check("lit bit1 result", 32'(result), 32'h01);

    // SET with three wait states on both phases: done at cycle 9.
    run_txn(2'b10, 6, 1'b0, 16'h5555, 8'h00, 3'd0, 3, 3);
    check("lit wait done_cycle", 32'(done_cycle), 32'd9);

    // Address wrap: 0xFFFF + 2 = 0x0001.
    run_txn(2'b00, 4, 1'b1, 16'hFFFF, 8'h02, 3'd0, 0, 0);
    check("lit wrap addr", 32'(seen_addr), 32'h0001);

    // Reset mid-write, then a normal request.
    reset_mid_write();
    mem[16'h0100] = 8'h10;
    run_txn(2'b10, 0, 1'b0, 16'h0100, 8'h00, 3'd0, 1, 0);
    check("lit post-reset result", 32'(result), 32'h11);

    // Illegal op: done/err at cycle 1 with no bus request.
    run_txn(2'b11, 2, 1'b0, 16'h0200, 8'h00, 3'd0, 0, 0);
    check("lit ill done_cycle", 32'(done_cycle), 32'd1);
    check("lit ill err", 32'(seen_err), 32'd1);
    check("lit ill no req", 32'(seen_req_since_start), 32'd0);

    // Indexed SET with a register copy target.
    mem[16'h3005] = 8'h00;
    run_txn(2'b10, 1, 1'b1, 16'h3000, 8'h05, 3'd2, 0, 0);
    check("lit copy result", 32'(result), 32'h02);
`ifdef Z80_UNDOC_INDEXED_COPY_EN
    check("lit copy reg_we", 32'(seen_reg_we), 32'd1);
    check("lit copy reg_wsel", 32'(reg_wsel), 32'd2);
`else
    check("lit copy reg_we", 32'(seen_reg_we), 32'd0);
`endif

    // Randomized requests.
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [1:0] o;
      r = int'($urandom_range(0, 9));
      o = (r == 0) ? 2'b11 : 2'(r % 3);
      run_txn(o, int'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 8'($urandom),
              3'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
